cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Moore state machine that sequences the single-ALU register-file datapath for one instruction at a time.
- Receives opcode/op from the instruction decoder and a start strobe `s`.
- Drives register-select (`nsel`), pipeline-register load enables, operand muxes, writeback mux and register-file write.
- Sits between the instruction register/decoder and the datapath inside the CPU top level.

Parameters:
None.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; forces S_WAIT
s  input  1  start; sampled only in S_WAIT
opcode  input  3  from decoder (110 = MOV, 101 = ALU)
op  input  2  from decoder
w  output  1  idle/ready, high only in S_WAIT
nsel  output  2  register select: 2'b10 = Rn, 2'b01 = Rd, 2'b00 = Rm
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status flags
asel  output  1  1 = A operand forced to 0
bsel  output  1  1 = B operand from sximm5 (always 0 for current ISA)
vsel  output  2  writeback source: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata
write  output  1  register-file write enable
err  output  1  one-cycle pulse on unsupported opcode/op

Behaviour:
- Reset is synchronous and active-high. When `reset` is high at a rising edge, the state becomes S_WAIT regardless of the current state; a mid-instruction reset abandons the instruction with no further write.
- All outputs are decoded from the state register only (pure Moore). Defaults in every state: all strobes 0, `nsel` = 00, `vsel` = 00, `asel` = 0, `bsel` = 0, `err` = 0.
- After reset: `w` = 1, all other outputs 0.
- `opcode`/`op` are captured into an internal register on the edge leaving S_WAIT (when `s` = 1). Later states use only the captured copy, so input changes mid-instruction have no effect.
- States, their outputs and transitions:
  - S_WAIT: `w` = 1. If `s` = 1, go to S_DECODE; otherwise stay.
  - S_DECODE: no strobes. Dispatch on the captured {opcode, op}:
    - 110_10 (MOV imm) -> S_WRITE_IMM
    - 110_00 (MOV reg) -> S_GET_B
    - 101_xx (ADD/CMP/AND/MVN) -> S_GET_A
    - anything else -> S_ERR
  - S_WRITE_IMM: `nsel` = 10, `vsel` = 10, `write` = 1. Go to S_WAIT.
  - S_GET_A: `nsel` = 10, `loada` = 1. Go to S_GET_B.
  - S_GET_B: `nsel` = 00, `loadb` = 1. Go to S_OPERATE.
  - S_OPERATE: `asel` = 1 for MOV reg, 0 otherwise; `bsel` = 0.
    - CMP (101_01): `loads` = 1, `loadc` = 0. Go to S_WAIT.
    - All others: `loadc` = 1. Go to S_WRITE_REG.
  - S_WRITE_REG: `nsel` = 01, `vsel` = 00, `write` = 1. Go to S_WAIT.
  - S_ERR: `err` = 1. Go to S_WAIT.
- Cycle counts, measured from the edge that samples `s` = 1 to `w` returning high:
  - MOV imm: 3 edges
  - MOV reg: 5 edges
  - CMP: 5 edges
  - ADD/AND/MVN: 6 edges
  - illegal: 3 edges
- `s` is ignored outside S_WAIT.
- If `s` is held high continuously, a new instruction starts on the first edge in S_WAIT (one idle cycle with `w` = 1 between instructions).
- Exactly one of `write`/`loads`/`err` is asserted per instruction; `write` is never asserted for CMP or illegal instructions.
- Reset has priority over `s` when both are high.
- Unreachable state encodings recover to S_WAIT on the next edge.

Test Plan:
- Reset then idle: hold `reset` = 1 for 1 edge, `s` = 0 for 5 edges -> `w` = 1 and all strobes 0 every cycle.
- MOV imm: opcode = 110, op = 10, pulse `s` -> sequence S_DECODE, then `write` = 1 with `nsel` = 10, `vsel` = 10 for exactly one cycle, then `w` = 1 on the 3rd edge after sampling `s`.
- ADD: opcode = 101, op = 00 -> in successive cycles `loada` (`nsel` = 10), `loadb` (`nsel` = 00), `loadc` (`asel` = 0), `write` (`nsel` = 01, `vsel` = 00); `w` high after 6 edges; `loads` never high.
- CMP and MOV reg:
  - CMP (101, 01): `loads` = 1 in S_OPERATE, `write` never asserted.
  - MOV reg (110, 00): no `loada`, `asel` = 1 during `loadc`, `write` to Rd (`nsel` = 01).
- Robustness: change `opcode` to 110 while in S_GET_A of an ADD -> ADD sequence completes unchanged. Assert `reset` in S_OPERATE -> S_WAIT next edge, no `write` pulse.
- Illegal and back-to-back: opcode = 000 -> `err` pulse for 1 cycle, no other strobes. Holding `s` = 1 across two MOV imm instructions -> two `write` pulses separated by the cycles S_WAIT (`w` = 1) and S_DECODE.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: Moore sequencer for the single-ALU register-file datapath.
// Runs one instruction at a time. The opcode/op pair is latched on start,
// and every output is decoded from the current state.
module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [1:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       err
);

  typedef enum logic [3:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_WRITE_IMM = 4'd2,
    S_GET_A     = 4'd3,
    S_GET_B     = 4'd4,
    S_OPERATE   = 4'd5,
    S_WRITE_REG = 4'd6,
    S_ERR       = 4'd7
  } state_t;

  // Captured {opcode, op} encodings
  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [2:0] OPC_ALU   = 3'b101;

  // Register select and writeback source codes
  localparam logic [1:0] NSEL_RN   = 2'b10;
  localparam logic [1:0] NSEL_RD   = 2'b01;
  localparam logic [1:0] NSEL_RM   = 2'b00;
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  state_t     state_q, state_d;
  logic [4:0] instr_q;

  // State register. The instruction is latched only when leaving S_WAIT, so
  // decoder changes in the middle of an instruction are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT && s) instr_q <= {opcode, op};
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    state_d = S_WAIT;
    w       = 1'b0;
    nsel    = NSEL_RM;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    vsel    = VSEL_C;
    write   = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_WAIT: begin
        w       = 1'b1;
        state_d = s ? S_DECODE : S_WAIT;
      end
      S_DECODE: begin
        if (instr_q == I_MOV_IMM)          state_d = S_WRITE_IMM;
        else if (instr_q == I_MOV_REG)     state_d = S_GET_B;
        else if (instr_q[4:2] == OPC_ALU)  state_d = S_GET_A;
        else                               state_d = S_ERR;
      end
      S_WRITE_IMM: begin
        nsel    = NSEL_RN;
        vsel    = VSEL_IMM8;
        write   = 1'b1;
        state_d = S_WAIT;
      end
      S_GET_A: begin
        nsel    = NSEL_RN;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        nsel    = NSEL_RM;
        loadb   = 1'b1;
        state_d = S_OPERATE;
      end
      S_OPERATE: begin
        // MOV reg passes B through the ALU with A forced to zero
        asel = (instr_q == I_MOV_REG);
        if (instr_q == I_CMP) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        nsel    = NSEL_RD;
        vsel    = VSEL_C;
        write   = 1'b1;
        state_d = S_WAIT;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_WAIT;
      end
      // Unused encodings fall back to idle on the next edge
      default: state_d = S_WAIT;
    endcase
  end

endmodule
